instruction_loader: RTL

Boot-time controller for the instruction memory. It takes a byte stream from the serial receiver, assembles big-endian 32-bit words, and writes them to consecutive instruction-memory addresses starting at 0. While loading it owns the memory port and holds the CPU. Once loading completes it hands the memory address port to the CPU fetch path and releases the CPU.

---
 rtl/instruction_loader_pkg.sv | 20 ++
 rtl/instruction_loader_byte_word_assembler.sv | 38 +++
 rtl/instruction_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the boot-time instruction loader and the instruction memory.
// MEM_SIZE lives here so the memory depth and the loader's word-count limit cannot drift apart.
package instruction_loader_pkg;

    localparam int MEM_SIZE       = 20000;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [1:0] ST_COUNT = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    typedef enum logic [1:0] {
        COUNT = ST_COUNT,
        DATA  = ST_DATA,
        DONE  = ST_DONE,
        ERROR = ST_ERROR
    } state_t;

endpackage

// File: rtl/instruction_loader_byte_word_assembler.sv
// Packs a serial byte stream into big-endian 32-bit words.
// o_word is the word completed by the current byte, so it is only meaningful while o_word_valid is high.
module instruction_loader_byte_word_assembler
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_enable,
    input  logic        i_restart,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_byte_idx;
    logic [31:0] r_word;
    logic        w_accept;

    assign w_accept = i_enable && i_rx_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
        end else if (i_restart) begin
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
        end else if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_word     <= {r_word[23:0], i_rx_data};
        end
    end

    assign o_word       = {r_word[23:0], i_rx_data};
    assign o_word_valid = w_accept && (r_byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: reads a word count then that many words from the serial stream into instruction memory,
// holding the CPU until the image is complete and then handing the memory address port to the fetch path.
module instruction_loader #(
    parameter int MEM_SIZE   = instruction_loader_pkg::MEM_SIZE,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          reload,
    input  logic [ADDR_WIDTH-1:0]         cpu_address,
    output logic                          mem_write_enable,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [31:0]                   mem_write_data,
    output logic                          cpu_enable,
    output logic                          load_error,
    output logic [ADDR_WIDTH-1:0]         words_loaded,
    output instruction_loader_pkg::state_t dbg_state
);

    import instruction_loader_pkg::*;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_load_addr;
    logic [ADDR_WIDTH-1:0] r_words_loaded;
    logic [31:0]           r_count;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [31:0]           w_word;
    logic                  w_word_valid;
    logic                  w_restart;
    logic                  w_assembler_en;
    logic                  w_count_load;
    logic                  w_last_write;
    logic [31:0]           w_words_next;

    instruction_loader_byte_word_assembler u_assembler (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_enable     (w_assembler_en),
        .i_restart    (w_restart),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // Compare at 32 bits so a count wider than the address counter is still caught.
    assign w_words_next = 32'(r_words_loaded) + 32'd1;
    assign w_last_write = r_we && (w_words_next == r_count);

    always_comb begin
        w_state_next   = r_state;
        w_restart      = 1'b0;
        w_assembler_en = 1'b0;
        w_count_load   = 1'b0;
        case (r_state)
            COUNT: begin
                w_assembler_en = 1'b1;
                if (w_word_valid) begin
                    w_count_load = 1'b1;
                    if (w_word == 32'd0)
                        w_state_next = DONE;
                    else if (w_word > 32'(MEM_SIZE))
                        w_state_next = ERROR;
                    else
                        w_state_next = DATA;
                end
            end
            DATA: begin
                w_assembler_en = 1'b1;
                if (w_last_write)
                    w_state_next = DONE;
            end
            DONE: begin
                if (reload) begin
                    w_state_next = COUNT;
                    w_restart    = 1'b1;
                end
            end
            ERROR: w_state_next = ERROR;
            default: w_state_next = COUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= COUNT;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we           <= 1'b0;
            r_wdata        <= 32'd0;
            r_count        <= 32'd0;
            r_load_addr    <= '0;
            r_words_loaded <= '0;
        end else begin
            r_we <= 1'b0;
            // Write data is latched separately so the assembler can keep taking bytes during the write.
            if (r_state == DATA && w_word_valid) begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
            end
            if (w_count_load)
                r_count <= w_word;
            if (w_restart) begin
                r_load_addr    <= '0;
                r_words_loaded <= '0;
            end else if (r_we) begin
                r_words_loaded <= r_words_loaded + 1'b1;
                if (r_load_addr != ADDR_WIDTH'(MEM_SIZE - 1))
                    r_load_addr <= r_load_addr + 1'b1;
            end
        end
    end

    assign mem_write_enable = r_we;
    assign mem_write_data   = r_wdata;
    assign mem_address      = (r_state == DONE) ? cpu_address : r_load_addr;
    assign cpu_enable       = (r_state == DONE);
    assign load_error       = (r_state == ERROR);
    assign words_loaded     = r_words_loaded;
    assign dbg_state        = r_state;

endmodule
